// File: rtl/spin_controller.sv
// rtl/spin_controller.sv - per-frame rotation angle generator with random direction reversals
module spin_controller #(
    parameter logic [15:0] SPEED0       = 16'd96,
    parameter logic [15:0] SPEED1       = 16'd160,
    parameter logic [15:0] SPEED2       = 16'd224,
    parameter logic [15:0] SPEED3       = 16'd320,
    parameter int          MIN_INTERVAL = 120,
    parameter int          HOLD_FRAMES  = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       run,
    input  logic [1:0] level,
    output logic [9:0] angle,
    output logic       update,
    output logic       dir,
    output logic       holding
);

    localparam logic [7:0] MIN_IV = 8'(MIN_INTERVAL);
    localparam logic [3:0] HOLD_N = 4'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] phase, phase_next;
    logic [15:0] lfsr, lfsr_next;
    logic [7:0]  interval, interval_next;
    logic [3:0]  hold_cnt, hold_cnt_next;
    logic        dir_next;
    logic        update_next;
    logic [15:0] speed;
    logic [15:0] lfsr_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= 16'd0;
            lfsr     <= LFSR_SEED;
            interval <= MIN_IV;
            hold_cnt <= 4'd0;
            dir      <= 1'b0;
            update   <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            lfsr     <= lfsr_next;
            interval <= interval_next;
            hold_cnt <= hold_cnt_next;
            dir      <= dir_next;
            update   <= update_next;
        end
    end

    always_comb begin
        case (level)
            2'd0:    speed = SPEED0;
            2'd1:    speed = SPEED1;
            2'd2:    speed = SPEED2;
            default: speed = SPEED3;
        endcase
    end

    // Galois right shift, taps 16'hB400
    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        state_next    = state;
        phase_next    = phase;
        lfsr_next     = lfsr;
        interval_next = interval;
        hold_cnt_next = hold_cnt;
        dir_next      = dir;
        update_next   = 1'b0;

        if (frame_tick) begin
            lfsr_next = lfsr_step;
            if (!run) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state_next    = SPIN;
                        interval_next = MIN_IV;
                    end
                    SPIN: begin
                        update_next = 1'b1;
                        phase_next  = dir ? (phase - speed) : (phase + speed);
                        if (interval == 8'd1) begin
                            // reload uses the pre-shift LFSR value
                            dir_next      = ~dir;
                            hold_cnt_next = HOLD_N;
                            state_next    = HOLD;
                            interval_next = MIN_IV + {1'b0, lfsr[6:0]};
                        end else begin
                            interval_next = interval - 8'd1;
                        end
                    end
                    HOLD: begin
                        update_next   = 1'b1;
                        hold_cnt_next = hold_cnt - 4'd1;
                        if (hold_cnt == 4'd1) begin
                            state_next = SPIN;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    assign angle   = phase[15:6];
    assign holding = (state == HOLD);

endmodule

// File: tb/tb_spin_controller.sv
// tb/tb_spin_controller.sv - directed self-checking bench for spin_controller
module tb_spin_controller;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       run;
    logic [1:0] level;
    logic [9:0] angle;
    logic       update;
    logic       dir;
    logic       holding;

    logic       w_run;
    logic [1:0] w_level;
    logic [9:0] w_angle;
    logic       w_update;
    logic       w_dir;
    logic       w_holding;

    int n_checks;
    int n_pass;

    logic [15:0] m_lfsr;
    logic [15:0] lfsr_prev;
    logic [15:0] rev_lfsr;
    logic [7:0]  exp_iv;
    logic [15:0] exp_phase;
    int          cnt;
    int          upd_seen;

    spin_controller #(
        .MIN_INTERVAL(4),
        .HOLD_FRAMES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .run       (run),
        .level     (level),
        .angle     (angle),
        .update    (update),
        .dir       (dir),
        .holding   (holding)
    );

    // speeds chosen so the wrap cases land on exact phase values
    spin_controller #(
        .SPEED0      (16'h0060),
        .SPEED1      (16'hFFC0),
        .SPEED2      (16'h0060),
        .MIN_INTERVAL(2),
        .HOLD_FRAMES (1)
    ) wdut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .run       (w_run),
        .level     (w_level),
        .angle     (w_angle),
        .update    (w_update),
        .dir       (w_dir),
        .holding   (w_holding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // one-cycle tick; returns sampling at the cycle after the tick edge
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        lfsr_prev = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        frame_tick = 1'b0;
        run = 1'b0;
        level = 2'd0;
        w_run = 1'b0;
        w_level = 2'd0;
        m_lfsr = 16'hACE1;
        repeat (2) @(negedge clk);

        check("rst_angle", angle, 10'd0);
        check("rst_update", update, 1'b0);
        check("rst_dir", dir, 1'b0);
        check("rst_holding", holding, 1'b0);
        check("rst_lfsr", dut.lfsr, 16'hACE1);
        check("rst_interval", dut.interval, 8'd4);
        rst_n = 1'b1;

        upd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (update) upd_seen++;
        end
        check("idle_update", upd_seen, 0);
        check("idle_angle", angle, 10'd0);
        check("idle_lfsr", dut.lfsr, m_lfsr);

        // wrap-around on the second instance
        w_run = 1'b1;
        tick();
        check("w_start_update", w_update, 1'b0);
        w_level = 2'd1;
        tick();
        check("w_step_ffc0", wdut.phase, 16'hFFC0);
        w_level = 2'd0;
        tick();
        check("w_wrap_up_phase", wdut.phase, 16'h0020);
        check("w_wrap_up_angle", w_angle, 10'd0);
        check("w_rev_dir", w_dir, 1'b1);
        tick();
        check("w_hold_phase", wdut.phase, 16'h0020);
        w_level = 2'd2;
        tick();
        check("w_wrap_dn_ffc0", wdut.phase, 16'hFFC0);
        w_level = 2'd0;
        tick();
        check("w_wrap_dn_phase", wdut.phase, 16'hFF60);
        check("w_wrap_dn_angle", w_angle, 10'd1021);
        w_run = 1'b0;
        tick();

        // spin start at level 3
        run = 1'b1;
        level = 2'd3;
        tick();
        check("start_update", update, 1'b0);
        check("start_angle", angle, 10'd0);
        check("start_interval", dut.interval, 8'd4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("spin_angle", angle, 10'(5 * i));
            check("spin_update", update, 1'b1);
            @(negedge clk);
            check("spin_update_low", update, 1'b0);
        end
        rev_lfsr = lfsr_prev;
        exp_iv = 8'd4 + {1'b0, rev_lfsr[6:0]};
        check("rev_dir", dir, 1'b1);
        check("rev_holding", holding, 1'b1);
        check("rev_interval", dut.interval, exp_iv);

        tick();
        check("hold1_angle", angle, 10'd20);
        check("hold1_update", update, 1'b1);
        check("hold1_holding", holding, 1'b1);
        tick();
        check("hold2_angle", angle, 10'd20);
        check("hold2_update", update, 1'b1);
        check("hold2_holding", holding, 1'b0);

        tick();
        check("rev_spin_angle", angle, 10'd15);
        cnt = 0;
        while (!holding && cnt < 200) begin
            tick();
            cnt++;
        end
        check("rev2_ticks", cnt, 32'(exp_iv) - 1);
        exp_phase = 16'd1280 - 16'(320 * int'(exp_iv));
        check("rev2_angle", angle, exp_phase[15:6]);
        check("rev2_dir", dir, 1'b0);

        // stop during HOLD
        run = 1'b0;
        tick();
        check("stop_holding", holding, 1'b0);
        check("stop_update", update, 1'b0);
        check("stop_angle", angle, exp_phase[15:6]);
        tick();
        check("stopped_update", update, 1'b0);
        run = 1'b1;
        tick();
        check("restart_update", update, 1'b0);
        check("restart_dir", dir, 1'b0);
        tick();
        exp_phase = exp_phase + 16'd320;
        check("restart_phase", dut.phase, exp_phase);
        check("restart_update2", update, 1'b1);

        // async reset between clock edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_angle", angle, 10'd0);
        check("arst_dir", dir, 1'b0);
        check("arst_holding", holding, 1'b0);
        check("arst_lfsr", dut.lfsr, 16'hACE1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/spin_controller.md
# spin_controller

Generates the playfield rotation angle consumed by the rotation stage. Once per video frame it advances a 16-bit phase accumulator by a level-dependent speed. At pseudo-random intervals it reverses the spin direction, inserting a short freeze at each reversal. It sits between the frame timing generator and the rotation stage, driving that stage's `angle` and `update` inputs.

## Interface
- `SPEED0`, default 16'd96: phase increment per frame, level 0.
- `SPEED1`, default 16'd160: phase increment per frame, level 1.
- `SPEED2`, default 16'd224: phase increment per frame, level 2.
- `SPEED3`, default 16'd320: phase increment per frame, level 3.
- `MIN_INTERVAL`, default 120: minimum number of frames between reversals.
- `HOLD_FRAMES`, default 8: number of frames the angle is frozen after a reversal.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `frame_tick`  in  1  single-cycle pulse, one per frame.
- `run`  in  1  game active; level-sensitive.
- `level`  in  2  speed select; sampled on `frame_tick`.
- `angle`  out  10  rotation angle, 1024 units per turn; equals `phase[15:6]`.
- `update`  out  1  one-cycle pulse when `angle` holds a new frame value.
- `dir`  out  1  spin direction: 0 = counter-clockwise (increment), 1 = clockwise (decrement).
- `holding`  out  1  high while in the HOLD state.

## Operation
- **Registers:** `phase[15:0]`, `lfsr[15:0]`, `interval[7:0]` down-counter, `hold_cnt[3:0]`, `state`, `dir`.
- **Reset:** all registers take their reset values asynchronously on `rst_n` low.
  - `phase` = 0, `dir` = 0, `update` = 0, `holding` = 0, `lfsr` = `LFSR_SEED`, `interval` = `MIN_INTERVAL`, `hold_cnt` = 0, `state` = IDLE.
- **LFSR:** 16-bit Galois, mask 16'hB400. Shifts right once on every `frame_tick`, in every state.
- **Speed:** chosen from `SPEED0`..`SPEED3` by `level`. Phase arithmetic is modulo 2^16; wrap-around in either direction is silent.
- **IDLE:**
  - `phase` and `dir` are held.
  - On `frame_tick` with `run` = 1: go to SPIN and set `interval` = `MIN_INTERVAL`. No phase step on this tick.
- **SPIN:**
  - On `frame_tick`: if `dir` = 0, `phase += speed`; otherwise `phase -= speed`.
  - On the same tick, `interval` decrements.
  - If `interval` = 1 before the decrement:
    - toggle `dir`;
    - set `hold_cnt` = `HOLD_FRAMES`;
    - go to HOLD;
    - reload `interval` = `MIN_INTERVAL` + `lfsr[6:0]`, using the LFSR value before this tick's shift.
  - The phase step on the reversal tick uses the old `dir`.
- **HOLD:**
  - On `frame_tick`: `phase` is unchanged and `hold_cnt` decrements.
  - When `hold_cnt` = 1 before the decrement, go to SPIN.
- **Stop:** `run` = 0 in any state, sampled on `frame_tick`, sends the block to IDLE. It takes priority over every other transition on that tick; `phase`, `dir` and `lfsr` are retained. `run` is ignored between ticks.
- **`level` changes** take effect on the next `frame_tick` only.
- **`update`:** asserted for exactly one cycle after every `frame_tick` processed in SPIN or HOLD, including ticks where the phase is unchanged. Never asserted in IDLE, or on the tick that leaves IDLE.
- **`holding`:** equals (`state` == HOLD).

## Timing
- **Latency:** a `frame_tick` at cycle N produces new `phase`, `angle`, `dir` and `holding` visible at cycle N+1, with `update` high during cycle N+1 only.
- **Downstream:** the rotation stage registers its result one cycle after `update`.
- **Back-to-back ticks** on consecutive cycles are each processed; the block needs no recovery cycles.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Reset mid-frame:** `rst_n` low at any time forces the reset values immediately. The first tick after release follows the IDLE rules.
- **Reversal period:** in SPIN, `interval` is always at least 1. A reversal occurs every `MIN_INTERVAL`..`MIN_INTERVAL`+127 SPIN ticks; HOLD ticks do not count toward the interval.

## Test plan
- **Reset and idle:** reset, then 5 ticks with `run` = 0 -> `angle` = 0, `update` never high, and `lfsr` advances 5 steps from 16'hACE1.
- **Spin start:** `run` = 1, `level` = 3, 5 ticks -> first tick enters SPIN with no `update`. Following 4 ticks give `phase` = 320, 640, 960, 1280, i.e. `angle` = 5, 10, 15, 20, each with a one-cycle `update` at N+1.
- **Wrap-around:** force `phase` = 16'hFFC0, `dir` = 1, `level` = 0, tick -> `phase` = 16'hFF60, `angle` = 1021. With `dir` = 0 from 16'hFFC0, tick -> `phase` = 16'h0020, `angle` = 0.
- **Reversal:** `MIN_INTERVAL` = 4, `HOLD_FRAMES` = 2 -> on the 4th SPIN tick the phase steps with the old `dir` and then `dir` toggles. `holding` is high for 2 ticks with `angle` constant and `update` still pulsing. Spin then resumes in reverse, and `interval` = 4 + `lfsr[6:0]`.
- **Stop:** `run` dropped during HOLD, then tick -> IDLE, `holding` = 0, no `update`. On restart, `dir` and `phase` are preserved.
- **Async reset:** assert `rst_n` low mid-cycle while spinning -> all outputs reach their reset values without waiting for a `clk` edge.
